// File: rtl/tetris_pkg.sv
// Shared types for the game plate opcode interface and the opcode issuer.
// Holds the opcode set, the issuer states, pending-request bit positions and the line score table.
package tetris_pkg;

  typedef enum logic [2:0] {
    eNop,
    eNew,
    eMoveLeft,
    eMoveRight,
    eMoveDown,
    eRotate,
    eCommit,
    eCheck
  } opcode_e;

  // eDoCommit/eDoCheck are the states that issue eCommit/eCheck; the names
  // differ only because both enums share this package scope.
  typedef enum logic [3:0] {
    eIdle,
    eSpawn,
    eSelect,
    eIssue,
    eWait,
    eDrop,
    eDoCommit,
    eDoCheck,
    eNewPiece,
    eOver
  } issuer_state_e;

  localparam int PEND_ROT   = 0;
  localparam int PEND_LEFT  = 1;
  localparam int PEND_RIGHT = 2;
  localparam int PEND_DOWN  = 3;
  localparam int PEND_GRAV  = 4;

  localparam logic [4:0][10:0] SCORE_TABLE = {11'd1200, 11'd300, 11'd100, 11'd40, 11'd0};

  function automatic logic [10:0] score_base(input logic [2:0] n);
    return (n <= 3'd4) ? SCORE_TABLE[n] : 11'd0;
  endfunction

endpackage

// File: rtl/game_opcode_issuer_gravity_timer.sv
// Level-scaled gravity timer: emits a one-cycle tick every period cycles while enabled.
// Period shrinks by gravity_step_p per level and never drops below gravity_min_p.
module gravity_timer #(
  parameter int unsigned gravity_base_p = 50000000,
  parameter int unsigned gravity_step_p = 4000000,
  parameter int unsigned gravity_min_p  = 2000000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_en,
  input  logic       i_clr,
  input  logic [3:0] i_level,
  output logic       o_tick
);

  logic [31:0] r_cnt;
  logic [31:0] w_prod;
  logic [31:0] w_period;
  logic [31:0] w_last;
  logic        w_wrap;

  assign w_prod = 32'(i_level) * gravity_step_p;

  // Clamp both the subtraction underflow and the minimum period.
  always_comb begin
    w_period = gravity_base_p - w_prod;
    if ((w_prod >= gravity_base_p) || ((gravity_base_p - w_prod) < gravity_min_p)) begin
      w_period = gravity_min_p;
    end
  end

  assign w_last = w_period - 32'd1;
  // >= so a level-up that shortens the period below the count still wraps at once.
  assign w_wrap = (r_cnt >= w_last);
  assign o_tick = i_en && !i_clr && w_wrap;

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_wrap ? 32'd0 : r_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/game_opcode_issuer.sv
// Opcode issuer for the game plate: serialises key and gravity requests into opcodes,
// runs the landing sequence and tracks lines, level, score and game over.
module game_opcode_issuer
  import tetris_pkg::*;
#(
  parameter int unsigned gravity_base_p = 50000000,
  parameter int unsigned gravity_step_p = 4000000,
  parameter int unsigned gravity_min_p  = 2000000,
  parameter int unsigned max_level_p    = 10
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic          key_left_i,
  input  logic          key_right_i,
  input  logic          key_rotate_i,
  input  logic          key_down_i,
  input  logic          key_drop_i,
  output opcode_e       opcode_o,
  output logic          opcode_v_o,
  input  logic          ready_i,
  input  logic          done_i,
  output logic          yumi_o,
  input  logic          landed_i,
  input  logic          lose_i,
  input  logic [2:0]    line_elim_i,
  input  logic          line_elim_v_i,
  output logic [15:0]   lines_o,
  output logic [3:0]    level_o,
  output logic [19:0]   score_o,
  output logic          game_over_o,
  output issuer_state_e o_dbg_state
);

  issuer_state_e r_state, w_state_nxt, r_src;
  opcode_e       r_op, w_sel_op;
  logic [4:0]    r_pend, w_pend_set, w_pend_clr;
  logic          r_drop, w_xfer, w_accept, w_done_ok, w_land, w_piece_done;
  logic          w_grav_en, w_grav_tick;
  logic [2:0]    w_n;
  logic [3:0]    r_lil, r_level, w_lil_sum, w_level_nxt;
  logic          w_level_up;
  logic [15:0]   r_lines, w_pts;
  logic [16:0]   w_lines_sum;
  logic [19:0]   r_score;
  logic [20:0]   w_score_sum;

  // Request handshake: opcode_o/opcode_v_o hold steady until the cycle with
  // opcode_v_o && ready_i (the transfer); then eWait holds the single
  // outstanding op until done_i, acknowledged combinationally by yumi_o.
  assign w_xfer       = opcode_v_o && ready_i;
  assign w_accept     = (r_state != eIdle) && (r_state != eOver);
  assign w_done_ok    = (r_state == eWait) && done_i && !lose_i;
  assign w_land       = w_done_ok && (r_op == eMoveDown) && landed_i;
  assign w_piece_done = w_done_ok && (r_src == eNewPiece);
  assign w_grav_en    = r_state inside {eSelect, eIssue, eWait, eDrop};

  always_comb begin
    w_sel_op = eNop;
    if (r_pend[PEND_ROT])                          w_sel_op = eRotate;
    else if (r_pend[PEND_LEFT])                    w_sel_op = eMoveLeft;
    else if (r_pend[PEND_RIGHT])                   w_sel_op = eMoveRight;
    else if (r_pend[PEND_DOWN] || r_pend[PEND_GRAV]) w_sel_op = eMoveDown;
  end

  always_comb begin
    w_state_nxt = r_state;
    opcode_o    = eNop;
    opcode_v_o  = 1'b0;
    yumi_o      = 1'b0;
    case (r_state)
      eIdle:     if (start_i) w_state_nxt = eSpawn;
      eSpawn:    begin opcode_o = eNew;      opcode_v_o = 1'b1; end
      eSelect: begin
        if (r_drop)       w_state_nxt = eDrop;
        else if (|r_pend) w_state_nxt = eIssue;
      end
      eIssue:    begin opcode_o = r_op;      opcode_v_o = 1'b1; end
      eDrop:     begin opcode_o = eMoveDown; opcode_v_o = 1'b1; end
      eDoCommit: begin opcode_o = eCommit;   opcode_v_o = 1'b1; end
      eDoCheck:  begin opcode_o = eCheck;    opcode_v_o = 1'b1; end
      eNewPiece: begin opcode_o = eNew;      opcode_v_o = 1'b1; end
      eWait: begin
        yumi_o = done_i;
        if (done_i) begin
          if (lose_i)      w_state_nxt = eOver;
          else if (w_land) w_state_nxt = eDoCommit;
          else begin
            case (r_src)
              eDrop:     w_state_nxt = eDrop;
              eDoCommit: w_state_nxt = eDoCheck;
              eDoCheck:  w_state_nxt = eNewPiece;
              default:   w_state_nxt = eSelect;
            endcase
          end
        end
      end
      default: ;
    endcase
    if (w_xfer) w_state_nxt = eWait;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= eIdle;
      r_src   <= eIdle;
      r_op    <= eNop;
    end else begin
      r_state <= w_state_nxt;
      if (w_xfer) begin
        r_op  <= opcode_o;
        r_src <= r_state;
      end else if ((r_state == eSelect) && (w_state_nxt == eIssue)) begin
        r_op  <= w_sel_op;
      end
    end
  end

  always_comb begin
    w_pend_set = {w_grav_tick, key_down_i, key_right_i, key_left_i, key_rotate_i} & {5{w_accept}};
    w_pend_clr = '0;
    if (w_xfer) begin
      case (opcode_o)
        eRotate:    w_pend_clr[PEND_ROT]   = 1'b1;
        eMoveLeft:  w_pend_clr[PEND_LEFT]  = 1'b1;
        eMoveRight: w_pend_clr[PEND_RIGHT] = 1'b1;
        eMoveDown: begin
          w_pend_clr[PEND_DOWN] = 1'b1;
          w_pend_clr[PEND_GRAV] = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // A fresh pulse beats a same-cycle clear; a fresh piece starts with nothing queued.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_pend <= '0;
      r_drop <= 1'b0;
    end else begin
      r_pend <= w_piece_done ? 5'd0 : ((r_pend & ~w_pend_clr) | w_pend_set);
      r_drop <= (r_drop && !w_land) || (key_drop_i && w_accept);
    end
  end

  assign w_n         = (line_elim_i <= 3'd4) ? line_elim_i : 3'd0;
  assign w_lil_sum   = r_lil + {1'b0, w_n};
  assign w_level_up  = (w_lil_sum >= 4'd10);
  assign w_level_nxt = (w_level_up && (r_level < 4'(max_level_p))) ? r_level + 4'd1 : r_level;
  // Points use the level reached after this report is applied.
  assign w_pts       = 16'(score_base(w_n)) * 16'({1'b0, w_level_nxt} + 5'd1);
  assign w_lines_sum = {1'b0, r_lines} + 17'(w_n);
  assign w_score_sum = {1'b0, r_score} + 21'(w_pts);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_lines <= '0;
      r_level <= '0;
      r_lil   <= '0;
      r_score <= '0;
    end else if (line_elim_v_i) begin
      r_lines <= w_lines_sum[16] ? 16'hFFFF : w_lines_sum[15:0];
      r_score <= w_score_sum[20] ? 20'hFFFFF : w_score_sum[19:0];
      r_lil   <= w_level_up ? w_lil_sum - 4'd10 : w_lil_sum;
      r_level <= w_level_nxt;
    end
  end

  gravity_timer #(
    .gravity_base_p(gravity_base_p),
    .gravity_step_p(gravity_step_p),
    .gravity_min_p (gravity_min_p)
  ) u_gravity (
    .i_clk  (clk_i),
    .i_reset(reset_i),
    .i_en   (w_grav_en),
    .i_clr  (w_piece_done),
    .i_level(r_level),
    .o_tick (w_grav_tick)
  );

  assign lines_o     = r_lines;
  assign level_o     = r_level;
  assign score_o     = r_score;
  assign game_over_o = (r_state == eOver);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_game_opcode_issuer.sv
// Bench for game_opcode_issuer: a small plate model answers each opcode with done_i,
// and every transferred opcode is checked in order against an expected queue.
module tb_game_opcode_issuer;
  import tetris_pkg::*;

  logic          clk = 1'b0;
  logic          reset_i, start_i;
  logic          key_left_i, key_right_i, key_rotate_i, key_down_i, key_drop_i;
  opcode_e       opcode_o;
  logic          opcode_v_o, ready_i, done_i, yumi_o, landed_i, lose_i;
  logic [2:0]    line_elim_i;
  logic          line_elim_v_i;
  logic [15:0]   lines_o;
  logic [3:0]    level_o;
  logic [19:0]   score_o;
  logic          game_over_o;
  issuer_state_e dbg_state;

  int         vectors = 0, miscompares = 0, cyc = 0;
  int         xfer_cnt = 0, done_cnt = 0, last_xfer_cyc = 0, land_cnt = 0;
  bit         lose_next = 1'b0, chk_grav = 1'b0;
  logic [2:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  game_opcode_issuer #(
    .gravity_base_p(20), .gravity_step_p(4), .gravity_min_p(8), .max_level_p(10)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .start_i(start_i),
    .key_left_i(key_left_i), .key_right_i(key_right_i), .key_rotate_i(key_rotate_i),
    .key_down_i(key_down_i), .key_drop_i(key_drop_i),
    .opcode_o(opcode_o), .opcode_v_o(opcode_v_o), .ready_i(ready_i),
    .done_i(done_i), .yumi_o(yumi_o), .landed_i(landed_i), .lose_i(lose_i),
    .line_elim_i(line_elim_i), .line_elim_v_i(line_elim_v_i),
    .lines_o(lines_o), .level_o(level_o), .score_o(score_o),
    .game_over_o(game_over_o), .o_dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_xfers(input int n, input string tag);
    int k = 0;
    while (xfer_cnt < n && k < 300) begin @(posedge clk); k++; end
    check(tag, 32'(xfer_cnt >= n), 32'd1);
  endtask

  task automatic wait_dones(input int n, input string tag);
    int k = 0;
    while (done_cnt < n && k < 300) begin @(posedge clk); k++; end
    check(tag, 32'(done_cnt >= n), 32'd1);
  endtask

  // k = {drop, down, right, left, rotate}
  task automatic pulse_keys(input logic [4:0] k);
    @(posedge clk); #1;
    {key_drop_i, key_down_i, key_right_i, key_left_i, key_rotate_i} = k;
    @(posedge clk); #1;
    {key_drop_i, key_down_i, key_right_i, key_left_i, key_rotate_i} = 5'd0;
  endtask

  task automatic elim(input logic [2:0] n);
    @(posedge clk); #1;
    line_elim_i = n; line_elim_v_i = 1'b1;
    @(posedge clk); #1;
    line_elim_i = 3'd0; line_elim_v_i = 1'b0;
  endtask

  task automatic check_stats(input string tag, input int lines, input int level, input int score);
    check({tag, "_lines"}, 32'(lines_o), 32'(lines));
    check({tag, "_level"}, 32'(level_o), 32'(level));
    check({tag, "_score"}, 32'(score_o), 32'(score));
  endtask

  // Monitor: scoreboard pop on every transfer.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_i && opcode_v_o && ready_i) begin
        xfer_cnt++;
        last_xfer_cyc = cyc;
        if (exp_q.size() == 0) check("op_unexpected", 32'(opcode_o), 32'(eNop));
        else                   check("op_order", 32'(opcode_o), 32'(exp_q.pop_front()));
      end
    end
  end

  // Plate model: one cycle of latency after transfer, then a one-cycle done_i.
  initial begin
    opcode_e cap_op;
    bit      cap_land, cap_lose, at_neg;
    done_i = 1'b0; landed_i = 1'b0; lose_i = 1'b0; at_neg = 1'b0;
    forever begin
      if (!at_neg) @(negedge clk);
      at_neg = 1'b0;
      if (!reset_i && opcode_v_o && ready_i) begin
        cap_op   = opcode_o;
        cap_land = 1'b0;
        cap_lose = lose_next;
        lose_next = 1'b0;
        if (cap_op == eMoveDown && land_cnt > 0) begin
          land_cnt--;
          cap_land = (land_cnt == 0);
        end
        @(posedge clk);
        @(negedge clk);
        check("valid_drop", 32'(opcode_v_o), 32'd0);
        @(posedge clk); #1;
        done_i = 1'b1; landed_i = cap_land; lose_i = cap_lose;
        @(negedge clk);
        check("yumi_hi", 32'(yumi_o), 32'd1);
        @(posedge clk); #1;
        done_i = 1'b0; landed_i = 1'b0; lose_i = 1'b0;
        done_cnt++;
        @(negedge clk);
        check("yumi_lo", 32'(yumi_o), 32'd0);
        if (chk_grav && cap_op == eNew) begin
          check("grav_cnt_zero", dut.u_gravity.r_cnt, 32'd0);
          chk_grav = 1'b0;
        end
        at_neg = 1'b1;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected under 40000", cyc);
    $fatal(1);
  end

  initial begin
    int t1;
    reset_i = 1'b1; start_i = 1'b0; ready_i = 1'b0;
    {key_drop_i, key_down_i, key_right_i, key_left_i, key_rotate_i} = 5'd0;
    line_elim_i = 3'd0; line_elim_v_i = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_i = 1'b0;
    @(negedge clk);
    check("rst_valid", 32'(opcode_v_o), 32'd0);
    check("rst_opcode", 32'(opcode_o), 32'(eNop));
    check("rst_yumi", 32'(yumi_o), 32'd0);
    check("rst_over", 32'(game_over_o), 32'd0);
    check_stats("rst", 0, 0, 0);

    // Spawn: eNew held while the plate is not ready.
    exp_q.push_back(eNew);
    @(posedge clk); #1 start_i = 1'b1;
    @(posedge clk); #1 start_i = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("hold_valid", 32'(opcode_v_o), 32'd1);
      check("hold_opcode", 32'(opcode_o), 32'(eNew));
    end
    @(posedge clk); #1 ready_i = 1'b1;
    wait_xfers(1, "spawn_xfer_timeout");
    wait_dones(1, "spawn_done_timeout");

    // Gravity alone: eMoveDown every 20 cycles at level 0.
    exp_q.push_back(eMoveDown);
    exp_q.push_back(eMoveDown);
    wait_xfers(2, "grav1_timeout");
    t1 = last_xfer_cyc;
    wait_xfers(3, "grav2_timeout");
    check("grav_period", 32'(last_xfer_cyc - t1), 32'd20);

    // Rotate+left together, then right twice (merges into one request).
    exp_q.push_back(eRotate);
    exp_q.push_back(eMoveLeft);
    exp_q.push_back(eMoveRight);
    pulse_keys(5'b00011);
    pulse_keys(5'b00100);
    pulse_keys(5'b00100);
    wait_xfers(6, "keys_timeout");

    // Next gravity step lands: commit/check/new follow.
    land_cnt = 1;
    exp_q.push_back(eMoveDown);
    exp_q.push_back(eCommit);
    exp_q.push_back(eCheck);
    exp_q.push_back(eNew);
    wait_xfers(10, "land_timeout");
    wait_dones(10, "land_done_timeout");

    // Hard drop landing on the third step.
    land_cnt = 3;
    chk_grav = 1'b1;
    repeat (3) exp_q.push_back(eMoveDown);
    exp_q.push_back(eCommit);
    exp_q.push_back(eCheck);
    exp_q.push_back(eNew);
    pulse_keys(5'b10000);
    wait_xfers(16, "drop_timeout");
    wait_dones(16, "drop_done_timeout");

    // Next gravity step reports lose; scoring runs meanwhile.
    lose_next = 1'b1;
    exp_q.push_back(eMoveDown);
    elim(3'd4); check_stats("elim1", 4, 0, 1200);
    elim(3'd4); check_stats("elim2", 8, 0, 2400);
    elim(3'd4); check_stats("elim3", 12, 1, 4800);
    elim(3'd5); check_stats("elim_bad", 12, 1, 4800);
    elim(3'd1); check_stats("elim_lvl1", 13, 1, 4880);

    wait_xfers(17, "lose_timeout");
    wait_dones(17, "lose_done_timeout");
    @(negedge clk);
    check("over_flag", 32'(game_over_o), 32'd1);
    pulse_keys(5'b00011);
    pulse_keys(5'b10000);
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("over_no_xfer", 32'(xfer_cnt), 32'd17);
    check("over_valid", 32'(opcode_v_o), 32'd0);
    check("over_sticky", 32'(game_over_o), 32'd1);

    @(posedge clk); #1 reset_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset_i = 1'b0;
    @(negedge clk);
    check("rst2_over", 32'(game_over_o), 32'd0);
    check("rst2_valid", 32'(opcode_v_o), 32'd0);
    check_stats("rst2", 0, 0, 0);
    check("exp_q_left", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
